// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Line levels and receiver state encoding shared by the UART
//               transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    LINE_WAIT = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_receiver_sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchroniser with a selectable reset level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : UART receiver, 1 start / DATA_BITS LSB-first / 1 stop bit,
//               mid-bit sampling with false-start rejection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int CLK_FREQ      = 50,
  parameter int BAUD_RATE     = 10,
  parameter int BAUD_RATE_DIV = CLK_FREQ / BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_error,
  output logic                 rx_busy
);

  localparam int CW   = $clog2(BAUD_RATE_DIV) + 1;
  localparam int BW   = $clog2(DATA_BITS) + 1;
  localparam int HALF = BAUD_RATE_DIV / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_RATE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  generate
    if (BAUD_RATE_DIV < 4) begin : g_div_check
      $error("uart_receiver: BAUD_RATE_DIV must be at least 4");
    end
    if (DATA_BITS < 2) begin : g_bits_check
      $error("uart_receiver: DATA_BITS must be at least 2");
    end
  endgenerate

  logic                 rx_sync;
  rx_state_t            state;
  logic [CW-1:0]        baud_counter;
  logic [BW-1:0]        bit_count;
  logic [DATA_BITS-1:0] shift_reg;

  sync_2ff #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_serial_in),
    .q     (rx_sync)
  );

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= LINE_WAIT;
      baud_counter   <= '0;
      bit_count      <= '0;
      shift_reg      <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      rx_valid       <= 1'b0;
      rx_frame_error <= 1'b0;
      case (state)
        // A line stuck low must go high before any start bit is accepted.
        LINE_WAIT: begin
          baud_counter <= '0;
          if (rx_sync == IDLE_LEVEL) state <= IDLE;
        end
        IDLE: begin
          baud_counter <= '0;
          if (rx_sync == START_LEVEL) state <= START;
        end
        START: begin
          if (baud_counter == HALF_LAST) begin
            baud_counter <= '0;
            bit_count    <= '0;
            state        <= (rx_sync == START_LEVEL) ? DATA : IDLE;
          end else begin
            baud_counter <= baud_counter + 1'b1;
          end
        end
        DATA: begin
          if (baud_counter == BAUD_LAST) begin
            shift_reg    <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            baud_counter <= '0;
            if (bit_count == BIT_LAST) state <= STOP;
            else bit_count <= bit_count + 1'b1;
          end else begin
            baud_counter <= baud_counter + 1'b1;
          end
        end
        STOP: begin
          if (baud_counter == BAUD_LAST) begin
            baud_counter <= '0;
            if (rx_sync == STOP_LEVEL) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              rx_frame_error <= 1'b1;
              state          <= LINE_WAIT;
            end
          end else begin
            baud_counter <= baud_counter + 1'b1;
          end
        end
        default: state <= LINE_WAIT;
      endcase
    end
  end

endmodule : uart_receiver

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  localparam int DATA_BITS = 8;
  localparam int DIV       = 5;
  localparam int HALF      = DIV / 2;
  localparam int STOP_OFS  = 2 + HALF + (DATA_BITS + 1) * DIV;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 rx_serial_in = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_error;
  logic                 rx_busy;

  uart_receiver #(
    .DATA_BITS (DATA_BITS),
    .CLK_FREQ  (50),
    .BAUD_RATE (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_serial_in   (rx_serial_in),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_frame_error (rx_frame_error),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 = valid word, 1 = framing error
    int         stamp;
    logic [7:0] data;
  } ev_t;

  ev_t        act_q[$];
  ev_t        exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         overlap  = 0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (rx_valid && rx_frame_error) overlap <= overlap + 1;
    if (rx_valid)       act_q.push_back('{kind: 0, stamp: cyc, data: rx_data});
    if (rx_frame_error) act_q.push_back('{kind: 1, stamp: cyc, data: rx_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a full frame from a negedge and records what the receiver owes us.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int gap);
    logic [9:0] bits;
    int         p;
    bits = {stop_bit, d, 1'b0};
    p    = 0;
    for (int k = 0; k < 10; k++) begin
      rx_serial_in = bits[k];
      if (k == 0) p = cyc + 1;
      repeat (DIV) @(negedge clk);
    end
    if (stop_bit) begin
      exp_q.push_back('{kind: 0, stamp: p + STOP_OFS, data: d});
      last_good = d;
    end else begin
      exp_q.push_back('{kind: 1, stamp: p + STOP_OFS, data: last_good});
    end
    rx_serial_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    rx_serial_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      rx_serial_in = d[k];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic compare_events(input string tag);
    chk({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("%s_kind%0d", tag, i),  32'(act_q[i].kind),  32'(exp_q[i].kind));
      chk($sformatf("%s_stamp%0d", tag, i), 32'(act_q[i].stamp), 32'(exp_q[i].stamp));
      chk($sformatf("%s_data%0d", tag, i),  32'(act_q[i].data),  32'(exp_q[i].data));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int p;
    logic [7:0] d;
    logic       ok_stop;
    int         gap;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(rx_data), 32'h0);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr",  32'(rx_frame_error), 32'h0);
    chk("rst_busy",  32'(rx_busy), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("recover_idle", 32'(rx_busy), 32'h0);
    repeat (2) @(negedge clk);

    // Single frame
    send_frame(8'hA5, 1'b1, 0);
    repeat (5) @(negedge clk);
    chk("a5_data", 32'(rx_data), 32'hA5);
    compare_events("a5");

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    repeat (5) @(negedge clk);
    compare_events("b2b");

    // One-cycle glitch
    rx_serial_in = 1'b0;
    p = cyc + 1;
    @(negedge clk);
    rx_serial_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", 32'(rx_busy), 32'h1);
    chk("glitch_cyc", 32'(cyc), 32'(p + 2));
    repeat (2) @(negedge clk);
    chk("glitch_busy_lo", 32'(rx_busy), 32'h0);
    repeat (5) @(negedge clk);
    compare_events("glitch");

    // Framing error, then line held low
    send_frame(8'h3C, 1'b0, 0);
    rx_serial_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("ferr_linewait_busy", 32'(rx_busy), 32'h1);
    rx_serial_in = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h11, 1'b1, 0);
    repeat (5) @(negedge clk);
    chk("ferr_next_data", 32'(rx_data), 32'h11);
    compare_events("ferr");

    // Reset in the middle of a frame
    send_partial(8'hC3, 4);
    reset = 1'b1;
    #1;
    chk("midrst_data",  32'(rx_data), 32'h0);
    chk("midrst_valid", 32'(rx_valid), 32'h0);
    chk("midrst_ferr",  32'(rx_frame_error), 32'h0);
    chk("midrst_busy",  32'(rx_busy), 32'h1);
    last_good = 8'h00;
    @(negedge clk);
    rx_serial_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b1, 0);
    repeat (5) @(negedge clk);
    compare_events("midrst");

    // Loopback-style sequence
    send_frame(8'h81, 1'b1, 0);
    send_frame(8'h7E, 1'b1, 0);
    send_frame(8'h00, 1'b1, 0);
    repeat (5) @(negedge clk);
    compare_events("loop");

    // Randomised frames with occasional bad stop bits and idle gaps
    for (int n = 0; n < 16; n++) begin
      d       = 8'($urandom);
      ok_stop = ($urandom_range(0, 5) != 0);
      gap     = ok_stop ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 5));
      send_frame(d, ok_stop, gap);
    end
    repeat (8) @(negedge clk);
    chk("rand_last_good", 32'(rx_data), 32'(last_good));
    compare_events("rand");

    chk("no_overlap", 32'(overlap), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_receiver

`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART RS-232 receiver, the receive-side counterpart of the team's UART transmitter. It uses the same framing: 1 start bit (0), DATA_BITS data bits LSB-first, and 1 stop bit (1), at CLK_FREQ/BAUD_RATE clocks per bit. It synchronises the asynchronous line, rejects false starts, samples each bit once per bit period, and presents each received word with a one-cycle valid pulse or a framing-error pulse.

## Interface
- DATA_BITS, 8: data bits per frame.
- CLK_FREQ, 50: clock frequency in Hz.
- BAUD_RATE, 10: line bit rate in baud.
- BAUD_RATE_DIV, CLK_FREQ/BAUD_RATE: clocks per bit. Elaboration fails if it is below 4.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_serial_in  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last good word; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  output  1  high whenever the state is not IDLE.

## Operation
- Synchroniser: rx_serial_in passes through two flops, both reset to 1. The output is rx_sync. All FSM decisions use rx_sync only.
- Constants: HALF = BAUD_RATE_DIV/2, using integer division.
- Counters:
  - baud_counter is $clog2(BAUD_RATE_DIV)+1 bits.
  - bit_count is $clog2(DATA_BITS)+1 bits.
  - shift_reg is DATA_BITS bits.
- State LINE_WAIT (reset state): wait for rx_sync==1, then go to IDLE. This prevents a line held low at reset or after a framing error from being taken as a start bit.
- State IDLE: baud_counter=0. If rx_sync==0, go to START.
- State START: baud_counter increments each cycle. When baud_counter==HALF-1:
  - if rx_sync==0 (start bit confirmed): go to DATA, with baud_counter=0 and bit_count=0;
  - otherwise (glitch): go to IDLE with no output activity.
- State DATA: when baud_counter==DIV-1:
  - shift right with rx_sync inserted at the MSB, so the word is received LSB-first;
  - set baud_counter=0;
  - if bit_count==DATA_BITS-1, go to STOP; otherwise increment bit_count.
- State STOP: when baud_counter==DIV-1:
  - if rx_sync==1: rx_data<=shift_reg, rx_valid<=1, go to IDLE;
  - otherwise: rx_frame_error<=1, rx_data unchanged, go to LINE_WAIT.
- rx_valid and rx_frame_error are registered and cleared on every cycle they are not set. They are never high together.
- Unreachable state encodings go to LINE_WAIT.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_frame_error=0, rx_busy=1 (state LINE_WAIT).
- Recovery after reset: the synchroniser flops reset high, so with the line high the block reaches IDLE one cycle after reset deasserts.
- Let P be the clock edge that first samples rx_serial_in low.
  - IDLE leaves at P+2.
  - The start bit is checked at P+2+HALF.
  - Data bit n is sampled at P+2+HALF+(n+1)·DIV.
  - The stop bit is sampled at P+2+HALF+(DATA_BITS+1)·DIV.
  - rx_valid is high in the following cycle. With the defaults (DIV=5, HALF=2, DATA_BITS=8) that is after edge P+49.
- Back-to-back frames: IDLE is re-entered right after the stop sample, about half a bit before the stop bit ends. The next start edge is therefore detected with no lost cycles.
- Tolerance: the sampling point is HALF clocks into each bit. The bit period must match the transmitter's BAUD_RATE_DIV exactly; no baud-error tracking is provided.
- Reset mid-frame: the block aborts immediately. The partial word is discarded and no pulse is produced.

## Structure
- Package uart_pkg holds:
  - typedef rx_state_t {LINE_WAIT, IDLE, START, DATA, STOP}, encoded in logic [2:0];
  - the IDLE_LEVEL, START_LEVEL and STOP_LEVEL constants shared with the transmitter.
- One sub-module: sync_2ff, a single-bit two-flop synchroniser with a RESET_VAL parameter, instantiated with RESET_VAL=1.

## Test plan
All scenarios use the defaults (DIV=5).
- Frame 0xA5 driven at 5 clocks/bit, start low at edge P -> rx_valid pulses for exactly 1 cycle after edge P+49; rx_data=0xA5; rx_frame_error stays 0.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses 50 cycles apart; rx_data is 0x00 then 0xFF.
- Line low for 1 cycle only -> rx_busy rises then falls within 5 cycles; no rx_valid and no rx_frame_error.
- Frame 0x3C with stop bit 0, then line held low for 20 cycles -> one rx_frame_error pulse; rx_data keeps its previous value; no new start until the line returns high and a fresh frame 0x11 is received correctly.
- reset asserted after data bit 3 of 0xC3 -> all outputs return to their reset values within the same cycle; no pulse occurs; the following frame 0x5A gives rx_data=0x5A.
- Loopback from the team transmitter sending 0x81, 0x7E and 0x00 -> three rx_valid pulses with matching rx_data; no framing errors.
